// File: rtl/onehot_index_decoder_pkg.sv
// Shared constants for the one-hot index decoder slice.
package onehot_index_decoder_pkg;
    localparam int DEFAULT_WIDTH = 16;
endpackage

// File: rtl/onehot_index_decoder_onehot_to_bin.sv
// Combinational OR-reduction decode of a mask into a binary index, plus zero/multi-hot flags.
module onehot_to_bin
    import onehot_index_decoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     zero_o,
    output logic                     multi_o
);
    localparam int IDX_W = $clog2(WIDTH);

    // Mask of all bit positions whose index has bit k set.
    function automatic logic [WIDTH-1:0] pos_mask(input int k);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int p = 0; p < WIDTH; p++) begin
            m[p] = ((p >> k) & 1) != 0;
        end
        return m;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_idx
            localparam logic [WIDTH-1:0] POS_MASK = pos_mask(gi);
            assign idx_o[gi] = |(in_i & POS_MASK);
        end
    endgenerate

    assign zero_o  = ~|in_i;
    assign multi_o = |(in_i & (in_i - WIDTH'(1)));
endmodule

// File: rtl/onehot_index_decoder.sv
// Two-stage valid/ready pipeline turning leftmost/rightmost one-hot masks into indices, span and flags.
module onehot_index_decoder
    import onehot_index_decoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [WIDTH-1:0]         data_left_i,
    input  logic [WIDTH-1:0]         data_right_i,
    input  logic                     data_val_i,
    output logic                     data_ready_o,
    output logic [$clog2(WIDTH)-1:0] left_idx_o,
    output logic [$clog2(WIDTH)-1:0] right_idx_o,
    output logic [$clog2(WIDTH)-1:0] span_o,
    output logic                     empty_o,
    output logic                     err_o,
    output logic                     data_val_o,
    input  logic                     data_ready_i
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             s1_val_q;
    logic [WIDTH-1:0] s1_left_q, s1_right_q;
    logic             s2_val_q;
    logic [IDX_W-1:0] left_idx_q, right_idx_q, span_q;
    logic             empty_q, err_q;

    logic [IDX_W-1:0] left_idx_d, right_idx_d, span_d;
    logic             empty_d, err_d;
    logic             l_zero, l_multi, r_zero, r_multi;
    logic             s2_load;

    onehot_to_bin #(.WIDTH(WIDTH)) u_left (
        .in_i    (s1_left_q),
        .idx_o   (left_idx_d),
        .zero_o  (l_zero),
        .multi_o (l_multi)
    );

    onehot_to_bin #(.WIDTH(WIDTH)) u_right (
        .in_i    (s1_right_q),
        .idx_o   (right_idx_d),
        .zero_o  (r_zero),
        .multi_o (r_multi)
    );

    always_comb begin
        empty_d = l_zero && r_zero;
        err_d   = l_multi || r_multi || (l_zero != r_zero) || (left_idx_d < right_idx_d);
        span_d  = (err_d || empty_d) ? '0 : left_idx_d - right_idx_d;
    end

    // s2 can take a new beat when it is empty or its current beat leaves this cycle.
    assign s2_load      = !s2_val_q || data_ready_i;
    assign data_ready_o = !s1_val_q || s2_load;

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            s1_val_q    <= 1'b0;
            s1_left_q   <= '0;
            s1_right_q  <= '0;
            s2_val_q    <= 1'b0;
            left_idx_q  <= '0;
            right_idx_q <= '0;
            span_q      <= '0;
            empty_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (data_ready_o) begin
                s1_val_q <= data_val_i;
                if (data_val_i) begin
                    s1_left_q  <= data_left_i;
                    s1_right_q <= data_right_i;
                end
            end
            if (s2_load) begin
                s2_val_q <= s1_val_q;
                // Fields hold their last values while no beat is present.
                if (s1_val_q) begin
                    left_idx_q  <= left_idx_d;
                    right_idx_q <= right_idx_d;
                    span_q      <= span_d;
                    empty_q     <= empty_d;
                    err_q       <= err_d;
                end
            end
        end
    end

    assign data_val_o  = s2_val_q;
    assign left_idx_o  = left_idx_q;
    assign right_idx_o = right_idx_q;
    assign span_o      = span_q;
    assign empty_o     = empty_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_onehot_index_decoder.sv
// Directed scoreboard bench for onehot_index_decoder at WIDTH=16.
module tb_onehot_index_decoder;
    localparam int WIDTH = 16;
    localparam int IDX_W = 4;

    typedef struct packed {
        logic [IDX_W-1:0] left;
        logic [IDX_W-1:0] right;
        logic [IDX_W-1:0] span;
        logic             empty;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             srst_i = 1'b1;
    logic [WIDTH-1:0] data_left_i = '0;
    logic [WIDTH-1:0] data_right_i = '0;
    logic             data_val_i = 1'b0;
    logic             data_ready_o;
    logic [IDX_W-1:0] left_idx_o, right_idx_o, span_o;
    logic             empty_o, err_o, data_val_o;
    logic             data_ready_i = 1'b1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic accepted;
    logic stall_prev = 1'b0;
    exp_t held;

    onehot_index_decoder #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk),
        .srst_i       (srst_i),
        .data_left_i  (data_left_i),
        .data_right_i (data_right_i),
        .data_val_i   (data_val_i),
        .data_ready_o (data_ready_o),
        .left_idx_o   (left_idx_o),
        .right_idx_o  (right_idx_o),
        .span_o       (span_o),
        .empty_o      (empty_o),
        .err_o        (err_o),
        .data_val_o   (data_val_o),
        .data_ready_i (data_ready_i)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        exp_t e;
        int li, ri, cl, cr;
        li = 0; ri = 0; cl = 0; cr = 0;
        for (int p = 0; p < WIDTH; p++) begin
            if (l[p]) begin li = li | p; cl++; end
            if (r[p]) begin ri = ri | p; cr++; end
        end
        e.left  = IDX_W'(li);
        e.right = IDX_W'(ri);
        e.empty = (cl == 0) && (cr == 0);
        e.err   = (cl > 1) || (cr > 1) || ((cl == 0) != (cr == 0)) || (li < ri);
        e.span  = (e.err || e.empty) ? '0 : IDX_W'(li - ri);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare/pop outputs and record inputs at the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (stall_prev) begin
            check("stall_val", 32'(data_val_o), 32'd1);
            check("stall_fields", 32'({left_idx_o, right_idx_o, span_o, empty_o, err_o}), 32'(held));
        end
        if (data_val_o && data_ready_i) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out observed=beat expected=none");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("left_idx", 32'(left_idx_o), 32'(e.left));
                check("right_idx", 32'(right_idx_o), 32'(e.right));
                check("span", 32'(span_o), 32'(e.span));
                check("empty", 32'(empty_o), 32'(e.empty));
                check("err", 32'(err_o), 32'(e.err));
                $display("tb: out left=%0d right=%0d span=%0d empty=%0b err=%0b",
                         left_idx_o, right_idx_o, span_o, empty_o, err_o);
            end
        end
        stall_prev = data_val_o && !data_ready_i;
        held = {left_idx_o, right_idx_o, span_o, empty_o, err_o};
        accepted = data_val_i && data_ready_o;
        if (accepted) sb.push_back(model(data_left_i, data_right_i));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        int n;
        data_left_i  = l;
        data_right_i = r;
        data_val_i   = 1'b1;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 20) begin
            cycle();
            n++;
        end
        data_val_i = 1'b0;
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_val", 32'(data_val_o), 32'd0);
        check("rst_ready", 32'(data_ready_o), 32'd1);
        check("rst_fields", 32'({left_idx_o, right_idx_o, span_o, empty_o, err_o}), 32'd0);
        #11 srst_i = 1'b0;
        @(posedge clk); #1;
        check("post_rst_val", 32'(data_val_o), 32'd0);
        check("post_rst_ready", 32'(data_ready_o), 32'd1);

        // Basic beat and two-cycle latency
        send(16'h0100, 16'h0004);
        check("lat_cycle1", 32'(data_val_o), 32'd0);
        cycle();
        check("lat_cycle2", 32'(data_val_o), 32'd1);
        drain();

        // Back-to-back patterns: empty, top bit, error cases, equal indices
        send(16'h0000, 16'h0000);
        send(16'h8000, 16'h8000);
        send(16'h0003, 16'h0001);
        send(16'h0004, 16'h0100);
        send(16'h0010, 16'h0000);
        send(16'h0000, 16'h0020);
        send(16'h0001, 16'h0001);
        send(16'h4000, 16'h0002);
        drain();

        // Backpressure: fill both stages, stall, then release
        data_ready_i = 1'b0;
        send(16'h0002, 16'h0001);
        send(16'h0004, 16'h0001);
        check("bp_ready_low", 32'(data_ready_o), 32'd0);
        data_left_i  = 16'h0008;
        data_right_i = 16'h0001;
        data_val_i   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("bp_hold_ready", 32'(data_ready_o), 32'd0);
        end
        data_val_i   = 1'b0;
        data_ready_i = 1'b1;
        for (int n = 3; n <= 6; n++) send(WIDTH'(1) << n, 16'h0001);
        drain();

        // Asynchronous reset mid-stream with both stages full
        data_ready_i = 1'b0;
        send(16'h0800, 16'h0002);
        send(16'h0400, 16'h0004);
        #2 srst_i = 1'b1;
        #1;
        check("arst_val", 32'(data_val_o), 32'd0);
        check("arst_ready", 32'(data_ready_o), 32'd1);
        check("arst_fields", 32'({left_idx_o, right_idx_o, span_o, empty_o, err_o}), 32'd0);
        sb.delete();
        stall_prev   = 1'b0;
        data_ready_i = 1'b1;
        cycle();
        check("arst_hold_val", 32'(data_val_o), 32'd0);
        #2 srst_i = 1'b0;
        @(posedge clk); #1;
        check("arst_rel_val", 32'(data_val_o), 32'd0);
        check("arst_rel_ready", 32'(data_ready_o), 32'd1);
        send(16'h0200, 16'h0008);
        check("arst_lat1", 32'(data_val_o), 32'd0);
        cycle();
        check("arst_lat2", 32'(data_val_o), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/onehot_index_decoder.md
Name: onehot_index_decoder

Overview:
- Companion to the priority encoder: consumes its one-hot leftmost/rightmost vectors and decodes them into binary bit indices, the span between them and integrity flags.
- Sits directly downstream of the encoder. Used where consumers need indices rather than masks.
- 2-stage pipeline with valid/ready handshake on both sides; full throughput and backpressure without data loss.

Parameters:
- WIDTH, 16, width of the one-hot input vectors; must be ≥2 and a power of two.
- IDX_W, $clog2(WIDTH), derived localparam; width of the index and span outputs; not overridable.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- srst_i  input  1  reset, asynchronous, active-high; clears all state immediately, with no clock edge required.
- data_left_i  input  WIDTH  one-hot leftmost-set-bit mask, or zero.
- data_right_i  input  WIDTH  one-hot rightmost-set-bit mask, or zero.
- data_val_i  input  1  input beat valid.
- data_ready_o  output  1  block can accept an input beat this cycle.
- left_idx_o  output  IDX_W  binary index of the data_left_i bit.
- right_idx_o  output  IDX_W  binary index of the data_right_i bit.
- span_o  output  IDX_W  left_idx minus right_idx.
- empty_o  output  1  both input masks were zero.
- err_o  output  1  input pair was malformed.
- data_val_o  output  1  output beat valid.
- data_ready_i  input  1  downstream accepts the output beat.

Behaviour:
- Reset:
  - On srst_i high, all stage valid flags and all output registers go to 0 asynchronously.
  - data_val_o=0 and data_ready_o=1 while srst_i is held high and on the first cycle after it releases.
  - A beat in flight when reset asserts is discarded.
- Handshake:
  - Input transfer occurs when data_val_i && data_ready_o.
  - Output transfer occurs when data_val_o && data_ready_i.
  - data_val_o may assert regardless of data_ready_i.
  - Once data_val_o is high, all output fields stay stable until the transfer.
- Stage 1 (s1):
  - Registers both masks plus a valid flag.
  - Advances when s1 is empty or s2 is empty or s2 is transferring.
  - data_ready_o = !s1_val || s1_adv. This is combinational from data_ready_i; no input-to-output combinational path exists on data.
- Stage 2 (s2): registers the decoded results (see the rules below) and drives the outputs directly.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to data_val_o when unstalled.
  - Throughput is 1 beat per cycle.
  - Simultaneous output transfer and new s1 load in the same cycle is supported, with no bubble.
- Index decode: bit k of the index is the OR of the input bits whose position has bit k set (OR-reduction). A zero mask decodes to 0.
- One-hot check: a mask is legal when (m & (m-1)) == 0, i.e. zero or one-hot.
- Flags:
  - empty_o=1 iff both masks are zero. In that case indices=0, span=0, err_o=0.
  - err_o=1 if any of these holds:
    - either mask is multi-hot;
    - exactly one mask is zero;
    - left_idx < right_idx.
  - When err_o=1:
    - left_idx_o and right_idx_o still show the OR-decoded values;
    - span_o is forced to 0;
    - empty_o=0.
- Span:
  - Unsigned IDX_W-bit subtraction, only computed when err_o=0.
  - No wrap-around is possible in the legal case.
  - Equal indices, including the single-set-bit case, give span 0.
- Stall behaviour:
  - Stall when both stages are full and data_ready_i=0.
  - data_ready_o=0 during the stall; no beat is overwritten or dropped; order is preserved.
- Idle behaviour: when data_val_o=0, the output data fields keep their last values (zero after reset). Bench compares fields only on valid.

Decomposition:
- No shared package types are required; IDX_W stays a local derived constant.
- One sub-module, onehot_to_bin (parameter WIDTH), is natural:
  - purely combinational;
  - outputs idx[IDX_W-1:0], zero and multi flags;
  - instantiated twice, for left and right.
- Pipeline registers, the handshake and flag and span logic stay in the top module.

Test Plan:
- WIDTH=16, left=16'h0100, right=16'h0004, data_ready_i=1 -> 2 cycles later data_val_o=1, left_idx=8, right_idx=2, span=6, empty=0, err=0.
- left=0, right=0 -> empty_o=1, idx=0/0, span=0, err=0. Separately, left=16'h8000, right=16'h8000 -> idx=15/15, span=0, err=0.
- Error cases, each giving err_o=1 and span_o=0:
  - left=16'h0003, right=16'h0001 (multi-hot);
  - left=16'h0004, right=16'h0100 (left_idx 2 < right_idx 8);
  - left=16'h0010, right=0 (one mask zero).
- Backpressure:
  - Stimulus: 6 back-to-back beats with left=1<<n, right=1, n=1..6; data_ready_i=0 for cycles 3-6.
  - Required: data_ready_o drops while both stages are full; all 6 beats are delivered in order with span=1..6; outputs are stable while stalled.
- Async reset: assert srst_i mid-clock during a stream -> data_val_o and all outputs go to 0 before the next edge. After release, the first new beat emerges 2 cycles after acceptance with no stale data.
